hazard_ctrl: RTL and testbench

- Central sequencer for the fetch/decode pipeline register and the PC of the RV32I 5-stage core.
- Detects load-use hazards and control redirects (jal, jalr, taken branch), all resolved in EX.
- Drives PC enable, IF/ID enable, IF/ID flush and ID/EX bubble insertion, replacing the ad-hoc flush/stall flag logic inside the pipe register.
- Sits between decode/execute and the PC, IF/ID and ID/EX registers.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_detect.sv | 19 +
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard sequencer.
package hazard_pkg;

   localparam int unsigned CNT_W       = 4;
   localparam int unsigned MAX_BUBBLES = 15;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      STALL = 2'd2
   } state_e;

   // Pipeline-register control bundle driven by the sequencer
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_flush;
   } pipe_ctl_t;

   localparam pipe_ctl_t CTL_RUN      = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
   localparam pipe_ctl_t CTL_REDIRECT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1};
   localparam pipe_ctl_t CTL_STALL    = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1};
   localparam pipe_ctl_t CTL_RESET    = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: EX load writes a register the ID instruction reads.
module hazard_detect (
   input  logic       ex_load,
   input  logic [4:0] ex_rd,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   output logic       load_use_c
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
   assign rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
   assign load_use_c = ex_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// PC / IF-ID / ID-EX sequencer for redirect flushes and load-use stalls.
// Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES      = 2,
   parameter int unsigned LOAD_STALL_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jal,
   input  logic        jalr,
   input  logic        branch_out,
   input  logic        ex_load,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   output logic        pc_en,
   output logic        ifid_en,
   output logic        ifid_flush,
   output logic        idex_flush,
   output logic        busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_cycles
`endif
);

   // The redirect / load-use cycle itself is the first bubble, so the counter covers the rest
   localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'((FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] STALL_RELOAD = CNT_W'((LOAD_STALL_CYCLES >= 2) ? LOAD_STALL_CYCLES - 2 : 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   pipe_ctl_t        ctl;
   logic             redirect;
   logic             load_use;

   assign redirect = jal || jalr || branch_out;

   hazard_detect u_detect (
      .ex_load    (ex_load),
      .ex_rd      (ex_rd),
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .load_use_c (load_use)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state and pipeline controls; a redirect overrides any state
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ctl     = CTL_RUN;
      busy    = (state_q != RUN);
      if (redirect) begin
         ctl = CTL_REDIRECT;
         if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
         end else begin
            state_d = RUN;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (load_use) begin
                  ctl = CTL_STALL;
                  if (LOAD_STALL_CYCLES > 1) begin
                     state_d = STALL;
                     cnt_d   = STALL_RELOAD;
                  end
               end
            end
            FLUSH: begin
               ctl = CTL_REDIRECT;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            STALL: begin
               ctl = CTL_STALL;
               if (cnt_q == '0) state_d = RUN;
               else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = RUN;
         endcase
      end
      // Reset forces a safe pipeline immediately, independent of the clock
      if (!rst_n) begin
         ctl  = CTL_RESET;
         busy = 1'b1;
      end
   end

   assign pc_en      = ctl.pc_en;
   assign ifid_en    = ctl.ifid_en;
   assign ifid_flush = ctl.ifid_flush;
   assign idex_flush = ctl.idex_flush;

`ifdef HAZARD_PERF_CNT_EN
   // Saturating bubble counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (!pc_en && (stall_cycles != '1))     stall_cycles <= stall_cycles + 32'd1;
         if (ifid_flush && (flush_cycles != '1)) flush_cycles <= flush_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: default build and a FLUSH=3/STALL=3 build side by side.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       rst_n;
      logic       jal;
      logic       jalr;
      logic       br;
      logic       ex_load;
      logic [4:0] ex_rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
   } stim_t;

   typedef struct packed {
      logic [4:0]  a;
      logic [4:0]  b;
      logic [31:0] sa;
      logic [31:0] fa;
   } exp_t;

   localparam stim_t IDLE = '{rst_n: 1'b1, jal: 1'b0, jalr: 1'b0, br: 1'b0, ex_load: 1'b0,
                              ex_rd: 5'd0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       jal = 1'b0, jalr = 1'b0, branch_out = 1'b0, ex_load = 1'b0;
   logic [4:0] ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
   logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;

   logic a_pc_en, a_ifid_en, a_ifid_flush, a_idex_flush, a_busy;
   logic b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_busy;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] a_stall_cycles, a_flush_cycles, b_stall_cycles, b_flush_cycles;
`endif

   int   n_tot = 0;
   int   n_bad = 0;
   int   fl_a = 0, st_a = 0, fl_b = 0, st_b = 0;
   int   perf_s = 0, perf_f = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   hazard_ctrl u_dut_a (
      .clk(clk), .rst_n(rst_n), .jal(jal), .jalr(jalr), .branch_out(branch_out),
      .ex_load(ex_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
      .idex_flush(a_idex_flush), .busy(a_busy)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(a_stall_cycles), .flush_cycles(a_flush_cycles)
`endif
   );

   hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .jal(jal), .jalr(jalr), .branch_out(branch_out),
      .ex_load(ex_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
      .idex_flush(b_idex_flush), .busy(b_busy)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(b_stall_cycles), .flush_cycles(b_flush_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: count of bubble cycles still owed after the current one
   // Output vector order: {pc_en, ifid_en, ifid_flush, idex_flush, busy}
   task automatic model(input int fc, input int lc, input stim_t s,
                        inout int fl, inout int st, output logic [4:0] o);
      logic redir, lu, bsy;
      redir = s.jal | s.jalr | s.br;
      lu    = s.ex_load && (s.ex_rd != 5'd0) &&
              ((s.u1 && s.rs1 == s.ex_rd) || (s.u2 && s.rs2 == s.ex_rd));
      bsy   = (fl > 0) || (st > 0);
      if (!s.rst_n) begin
         fl = 0; st = 0; o = 5'b00111;
      end else if (redir) begin
         o = {4'b1111, bsy}; fl = fc - 1; st = 0;
      end else if (fl > 0) begin
         o = 5'b11111; fl--;
      end else if (st > 0) begin
         o = 5'b00011; st--;
      end else if (lu) begin
         o = 5'b00010; st = lc - 1;
      end else begin
         o = 5'b11000;
      end
   endtask

   task automatic step(input stim_t s);
      exp_t e, g;
      @(posedge clk);
      #1;
      rst_n = s.rst_n; jal = s.jal; jalr = s.jalr; branch_out = s.br;
      ex_load = s.ex_load; ex_rd = s.ex_rd; id_rs1 = s.rs1; id_rs2 = s.rs2;
      id_use_rs1 = s.u1; id_use_rs2 = s.u2;
      model(2, 1, s, fl_a, st_a, e.a);
      model(3, 3, s, fl_b, st_b, e.b);
      if (!s.rst_n) begin perf_s = 0; perf_f = 0; end
      e.sa = 32'(perf_s);
      e.fa = 32'(perf_f);
      if (s.rst_n && !e.a[4]) perf_s++;
      if (s.rst_n && e.a[2])  perf_f++;
      sb_q.push_back(e);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         g = sb_q.pop_front();
         chk("outs_a", 32'({a_pc_en, a_ifid_en, a_ifid_flush, a_idex_flush, a_busy}), 32'(g.a));
         chk("outs_b", 32'({b_pc_en, b_ifid_en, b_ifid_flush, b_idex_flush, b_busy}), 32'(g.b));
`ifdef HAZARD_PERF_CNT_EN
         chk("stall_cycles", a_stall_cycles, g.sa);
         chk("flush_cycles", a_flush_cycles, g.fa);
`endif
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(IDLE);
   endtask

   function automatic stim_t lu_stim(input logic [4:0] rd);
      stim_t s;
      s = IDLE;
      s.ex_load = 1'b1; s.ex_rd = rd; s.rs1 = 5'd5; s.u1 = 1'b1;
      return s;
   endfunction

   initial begin
      stim_t s;
      // Reset held three cycles, then release
      s = IDLE; s.rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step(s);
      idle(3);
      // Load-use, then the x0 destination that must not stall
      step(lu_stim(5'd5)); idle(4);
      step(lu_stim(5'd0)); idle(2);
      s = lu_stim(5'd7); s.rs1 = 5'd1; s.rs2 = 5'd7; s.u2 = 1'b1;
      step(s); idle(4);
      // Branch flush
      s = IDLE; s.br = 1'b1; step(s); idle(4);
      // Branch and load-use together
      s = lu_stim(5'd5); s.br = 1'b1; step(s); idle(4);
      // jalr on the second stall cycle
      step(lu_stim(5'd5));
      s = lu_stim(5'd5); s.jalr = 1'b1; step(s); idle(5);
      // Back-to-back redirects re-arm the flush
      s = IDLE; s.jal = 1'b1; step(s); step(s); idle(4);
      // Perf scenario: 4 load-use and 2 jal, then a reset pulse
      for (int i = 0; i < 4; i++) begin step(lu_stim(5'd5)); idle(3); end
      s = IDLE; s.jal = 1'b1;
      for (int i = 0; i < 2; i++) begin step(s); idle(3); end
      s = IDLE; s.rst_n = 1'b0; step(s);
      idle(2);
      // Reset asserted mid-stall
      step(lu_stim(5'd9));
      s = lu_stim(5'd9); s.rs1 = 5'd9; s.rst_n = 1'b0; step(s);
      idle(2);
      // Random traffic with small register indices to provoke hits
      for (int i = 0; i < 400; i++) begin
         s.rst_n   = ($urandom_range(0, 59) != 0);
         s.jal     = ($urandom_range(0, 11) == 0);
         s.jalr    = ($urandom_range(0, 15) == 0);
         s.br      = ($urandom_range(0, 9) == 0);
         s.ex_load = ($urandom_range(0, 2) == 0);
         s.ex_rd   = 5'($urandom_range(0, 3));
         s.rs1     = 5'($urandom_range(0, 3));
         s.rs2     = 5'($urandom_range(0, 3));
         s.u1      = 1'($urandom_range(0, 1));
         s.u2      = 1'($urandom_range(0, 1));
         step(s);
      end
      idle(3);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
